// File: rtl/flip_flop_bank_arbiter.sv
// -----------------------------------------------------------------------------
// flip_flop_bank_arbiter
//
// Round-robin arbiter and load controller for one shared WIDTH-bit bank of
// D flip-flops. Up to four requesters compete for the bank; the granted
// requester's data is clocked into the bank on every edge it keeps its
// request asserted. q is the only path out of the bank.
//
// Parameters
//   N_REQ      number of requesters (2..4)
//   WIDTH      width of the shared flip-flop bank
//   MAX_BURST  consecutive loads before forced rotation (burst limit only)
//
// Ports
//   clk      in   rising-edge clock
//   reset_L  in   asynchronous active-low reset
//   req      in   level request per requester
//   d_in     in   flattened data, requester i at d_in[i*WIDTH +: WIDTH]
//   gnt      out  registered one-hot grant, all-zero when idle
//   owner    out  index of the current grant holder, held while idle
//   q        out  shared flip-flop bank contents
//   q_valid  out  high for the cycle following each load edge
//
// Build option
//   DFF_ARB_BURST_LIMIT_EN  when defined, the owner is forced to hand the
//                           grant to another requester after MAX_BURST loads.
// -----------------------------------------------------------------------------
module flip_flop_bank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   d_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [1:0]               owner,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [1:0]         r_owner, w_owner_nxt;
    logic [1:0]         r_last, w_last_nxt;
    logic [CW-1:0]      r_burst, w_burst_nxt;
    logic [WIDTH-1:0]   r_q, w_q_nxt;
    logic               r_q_valid, w_q_valid_nxt;

    logic               w_owner_req;
    logic [WIDTH-1:0]   w_owner_data;
    logic [N_REQ-1:0]   w_pick_all;
`ifdef DFF_ARB_BURST_LIMIT_EN
    logic [N_REQ-1:0]   w_pick_others;
`endif

    // First set candidate scanning last+1, last+2, ... (modulo N_REQ),
    // returned one-hot. The inner loop keeps every bit select constant.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] cand,
                                                 input logic [1:0]       last);
        logic [N_REQ-1:0] onehot;
        logic             found;
        onehot = '0;
        found  = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && cand[i] && (i == (int'(last) + off) % N_REQ)) begin
                    onehot[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return onehot;
    endfunction

    function automatic logic [1:0] to_index(input logic [N_REQ-1:0] onehot);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // In BUSY the grant vector is one-hot on the owner, so it doubles as the
    // select for the owner's request bit and data lane.
    always_comb begin
        w_owner_req  = |(req & r_gnt);
        w_owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) w_owner_data = d_in[i*WIDTH +: WIDTH];
        end
    end

    assign w_pick_all = rr_pick(req, r_last);
`ifdef DFF_ARB_BURST_LIMIT_EN
    // Owner equals last while busy, so masking the owner leaves only others.
    assign w_pick_others = rr_pick(req & ~r_gnt, r_last);
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case below leaves one unassigned, which would infer a latch.
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_burst_nxt   = r_burst;
        w_q_nxt       = r_q;
        w_q_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_gnt_nxt   = w_pick_all;
                    w_owner_nxt = to_index(w_pick_all);
                    w_last_nxt  = to_index(w_pick_all);
                    w_burst_nxt = '0;
                    w_state_nxt = BUSY;
                end else begin
                    w_gnt_nxt = '0;
                end
            end

            BUSY: begin
                if (w_owner_req) begin
                    w_q_nxt       = w_owner_data;
                    w_q_valid_nxt = 1'b1;
                    if (r_burst != CW'(MAX_BURST)) begin
                        w_burst_nxt = r_burst + CW'(1);
                    end
`ifdef DFF_ARB_BURST_LIMIT_EN
                    // This edge performs load number MAX_BURST of the burst.
                    if (r_burst == CW'(MAX_BURST - 1)) begin
                        w_burst_nxt = '0;
                        if (|w_pick_others) begin
                            w_gnt_nxt   = w_pick_others;
                            w_owner_nxt = to_index(w_pick_others);
                            w_last_nxt  = to_index(w_pick_others);
                        end
                    end
`endif
                end else if (|req) begin
                    // Owner released: hand over on the same edge, no bubble.
                    w_gnt_nxt   = w_pick_all;
                    w_owner_nxt = to_index(w_pick_all);
                    w_last_nxt  = to_index(w_pick_all);
                    w_burst_nxt = '0;
                end else begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_last    <= 2'(N_REQ - 1);
            r_burst   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_burst   <= w_burst_nxt;
            r_q       <= w_q_nxt;
            r_q_valid <= w_q_valid_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign q       = r_q;
    assign q_valid = r_q_valid;

endmodule

// File: tb/tb_flip_flop_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flip_flop_bank_arbiter
//
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the arbitration rules kept in this file.
// -----------------------------------------------------------------------------
module tb_flip_flop_bank_arbiter;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
`ifdef DFF_ARB_BURST_LIMIT_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic                     clk     = 1'b0;
    logic                     reset_L = 1'b1;
    logic [N_REQ-1:0]         req     = '0;
    logic [N_REQ*WIDTH-1:0]   d_in    = '0;
    logic [N_REQ-1:0]         gnt;
    logic [1:0]               owner;
    logic [WIDTH-1:0]         q;
    logic                     q_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_busy;
    int          m_owner;
    int          m_last;
    int          m_loads;
    logic [7:0]  m_q;
    logic        m_qv;

    flip_flop_bank_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .req     (req),
        .d_in    (d_in),
        .gnt     (gnt),
        .owner   (owner),
        .q       (q),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin winner among r after last, skipping excl; -1 if none.
    function automatic int rr_winner(input logic [3:0] r, input int last, input int excl);
        for (int k = 1; k <= N_REQ; k++) begin
            int i;
            i = (last + k) % N_REQ;
            if (i != excl && ((r >> i) & 4'b0001) != 4'b0000) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N_REQ - 1;
        m_loads = 0;
        m_q     = '0;
        m_qv    = 1'b0;
    endtask

    task automatic model_step();
        int w;
        if (!m_busy) begin
            m_qv = 1'b0;
            w = rr_winner(req, m_last, -1);
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_last = w; m_loads = 0;
            end
        end else if (((req >> m_owner) & 4'b0001) != 4'b0000) begin
            m_q  = 8'(d_in >> (m_owner * WIDTH));
            m_qv = 1'b1;
            if (m_loads < MAX_BURST) m_loads++;
            if (BURST_ON && m_loads == MAX_BURST) begin
                m_loads = 0;
                w = rr_winner(req, m_last, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_last = w;
                end
            end
        end else begin
            m_qv = 1'b0;
            w = rr_winner(req, m_last, -1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_loads = 0;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        logic [3:0] exp_gnt;
        exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        check({ctx, ".gnt"},     32'(gnt),     32'(exp_gnt));
        check({ctx, ".owner"},   32'(owner),   32'(m_owner));
        check({ctx, ".q"},       32'(q),       32'(m_q));
        check({ctx, ".q_valid"}, 32'(q_valid), 32'(m_qv));
    endtask

    // One rising edge; outputs sampled 1 time unit later.
    task automatic cycle(input string ctx);
        @(posedge clk);
        if (reset_L) model_step();
        #1;
        compare_all(ctx);
    endtask

    // Asynchronous reset pulse placed between edges, released on a falling edge.
    task automatic apply_reset(input string ctx);
        #2 reset_L = 1'b0;
        model_reset();
        #1 compare_all(ctx);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        int cur;
        int seq [5] = '{0, 1, 2, 3, 0};

        // 1: reset with every request asserted, including across a rising edge.
        req = 4'b1111;
        apply_reset("t1");
        check("t1.gnt",   32'(gnt),     32'h0);
        check("t1.q",     32'(q),       32'h0);
        check("t1.qv",    32'(q_valid), 32'h0);
        check("t1.owner", 32'(owner),   32'h0);

        // 2: single requester 2.
        req  = 4'b0100;
        d_in = 32'h00A5_0000;
        cycle("t2.e1");
        check("t2.gnt", 32'(gnt), 32'h4);
        cycle("t2.e2");
        check("t2.q",  32'(q),       32'hA5);
        check("t2.qv", 32'(q_valid), 32'h1);

        // 3: fairness, each owner drops after one load.
        apply_reset("t3.rst");
        req  = 4'b1111;
        d_in = 32'hD3C2_B1A0;
        cycle("t3.g0");
        check("t3.owner0", 32'(owner), 32'(seq[0]));
        cur = seq[0];
        for (int g = 1; g < 5; g++) begin
            cycle("t3.load");
            check("t3.qv", 32'(q_valid), 32'h1);
            req = 4'b1111 & ~(4'b0001 << cur);
            cycle("t3.regrant");
            check("t3.owner", 32'(owner), 32'(seq[g]));
            check("t3.gnt",   32'(gnt),   32'(4'b0001 << seq[g]));
            cur = seq[g];
            req = 4'b1111;
        end

        // 4: owner 1 releases to idle.
        apply_reset("t4.rst");
        req  = 4'b0010;
        d_in = 32'h0000_5E00;
        cycle("t4.grant");
        cycle("t4.load");
        req = 4'b0000;
        cycle("t4.release");
        check("t4.gnt", 32'(gnt),     32'h0);
        check("t4.q",   32'(q),       32'h5E);
        check("t4.qv",  32'(q_valid), 32'h0);
        cycle("t4.idle");
        check("t4.q_hold", 32'(q), 32'h5E);

        // 5: reset in the middle of owner 3's burst.
        apply_reset("t5.rst");
        req  = 4'b1000;
        d_in = 32'h3C00_0000;
        cycle("t5.grant");
        check("t5.owner3", 32'(owner), 32'h3);
        cycle("t5.load");
        check("t5.q", 32'(q), 32'h3C);
        apply_reset("t5.mid");
        check("t5.q0",   32'(q),   32'h0);
        check("t5.gnt0", 32'(gnt), 32'h0);
        req = 4'b1001;
        cycle("t5.after");
        check("t5.owner0", 32'(owner), 32'h0);

        // 6: two requesters held continuously.
        apply_reset("t6.rst");
        req = 4'b0011;
        for (int e = 1; e <= 12; e++) begin
            d_in = $urandom;
            cycle("t6");
            if (e == 5) check("t6.owner_e5", 32'(owner), BURST_ON ? 32'h1 : 32'h0);
            if (e == 8) check("t6.owner_e8", 32'(owner), BURST_ON ? 32'h1 : 32'h0);
        end

        // Randomized traffic with occasional asynchronous resets.
        apply_reset("rnd.rst");
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            end
            d_in = $urandom;
            if ($urandom_range(63) == 0) apply_reset("rnd.rst");
            else                          cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
